core_dmem_responder: RTL
========================

// Module: core_dmem_responder
// PURPOSE
//  - Data-memory responder for the pipeline core's single-shot load/store strobes.
//  - Answers with the BUSY/DONE handshake and returns RDATA already right-justified and sign/zero-extended.
//  - Sits between the core's EX/MEM request fields and a word-organised on-chip SRAM.
//  - Wait states are programmable so pipeline stall paths can be exercised.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address that maps to word 0
//  DEPTH_WORDS  1024           SRAM depth in 32-bit words (power of 2)
//  WAIT_CYCLES  1              extra cycles between request capture and DONE (0..15)
//  INIT_FILE    ""             $readmemh image; empty string = no preload
// PORTS
//  CLK         in   1   clock, rising edge
//  NRST        in   1   reset, synchronous, active-low
//  ISLOAD_SS   in   1   one-cycle load request strobe
//  ISSTORE_SS  in   1   one-cycle store request strobe
//  ADDR        in   32  byte address of the access
//  STRB        in   4   byte-lane enables, lane-aligned to ADDR[1:0]
//  ISLOADBS    in   1   load byte signed (LB); 0 = LBU when 1 lane is set
//  ISLOADHWS   in   1   load half signed (LH); 0 = LHU when 2 lanes are set
//  WDATA       in   32  store data, lane-aligned
//  RDATA       out  32  load result, right-justified and extended
//  BUSY        out  1   request accepted, response not yet given
//  DONE        out  1   one-cycle completion pulse
//  ERR         out  1   misaligned/out-of-range flag (only with DMEM_CHECK_EN)
// BEHAVIOUR
//  - Reset: RDATA=0, BUSY=0, DONE=0, ERR=0, FSM=IDLE, wait counter=0.
//  - Reset does not clear SRAM contents.
//  - IDLE, on a strobe at edge N:
//      - capture ADDR, STRB, WDATA, ISLOADBS, ISLOADHWS and the op;
//      - BUSY=1 from N+1; go to WAIT, or to RESP if WAIT_CYCLES=0.
//  - WAIT: count down WAIT_CYCLES, then go to RESP.
//  - RESP: one cycle.
//      - DONE=1 and BUSY=0 in the same cycle.
//      - DONE lands at N+1+WAIT_CYCLES.
//      - Store: byte lanes selected by STRB are written at this edge only.
//      - Load: RDATA is updated at this edge.
//      - Next state IDLE.
//  - RDATA holds its value until the next load's DONE; stores never change it.
//  - Strobes while BUSY=1 or DONE=1 are ignored (no queueing).
//  - ISLOAD_SS and ISSTORE_SS together: treated as a store; the load is dropped.
//  - Load extraction:
//      - shift the word right by 8*ADDR[1:0];
//      - size comes from popcount(STRB): 1 = byte, 2 = half, 4 = word;
//      - byte/half are sign-extended if ISLOADBS/ISLOADHWS, else zero-extended;
//      - STRB=0 gives RDATA=0.
//  - Index = (ADDR-BASE_ADDR)>>2.
//      - A load at index >= DEPTH_WORDS returns 0.
//      - A store at index >= DEPTH_WORDS is dropped.
//      - DONE is still given in both cases.
//  - NRST low mid-transaction: the transaction is aborted, no write commits, no DONE.
// CONFIGURATION
//  - Macro DMEM_CHECK_EN defined:
//      - ERR is asserted together with DONE, for one cycle only, when the access is misaligned or out of range;
//      - misaligned = half with ADDR[0]=1, word with ADDR[1:0]!=0, or non-contiguous STRB;
//      - on ERR the store is suppressed and RDATA is forced to 0.
//  - Macro not defined:
//      - ERR is tied to 0;
//      - misaligned accesses execute as lane-masked operations;
//      - the check logic is absent.
// STRUCTURE
//  - Shared header define.vh gets:
//      - FSM state encodings (DMEM_ST_IDLE/WAIT/RESP);
//      - load-size codes (LSZ_BYTE/HALF/WORD).
//  - Sub-module core_dmem_lane: combinational extract + extend (word, addr[1:0], strb, signed flags -> rdata).
//  - Top holds the FSM, wait counter, capture registers and the SRAM array.
// TESTING
//  - Store then read back (WAIT_CYCLES=2):
//      - SW 0xDEADBEEF to 0x10 at cycle 5 -> BUSY on cycles 6-7, DONE at cycle 8;
//      - LW from 0x10 -> RDATA=0xDEADBEEF with DONE.
//  - Signed byte load:
//      - memory word 0x80FF7F01 at 0x20;
//      - LB from 0x23 (STRB=1000, ISLOADBS=1) -> 0xFFFFFF80;
//      - LBU from 0x23 -> 0x00000080.
//  - Halfword load and byte store:
//      - LHU from 0x22 -> 0x000080FF; LH from 0x22 -> 0xFFFF80FF;
//      - SB 0x55 to 0x21 (STRB=0010) -> word becomes 0x80FF5501.
//  - Busy and collision handling:
//      - second strobe while BUSY -> ignored, exactly one DONE;
//      - load and store strobes in the same cycle -> store executes.
//  - Reset abort: NRST low during WAIT of a store -> no DONE, memory word unchanged, BUSY=0 next cycle.
//  - Check feature:
//      - DMEM_CHECK_EN defined: LW at 0x12 -> ERR=1 with DONE, RDATA=0;
//      - macro undefined: same access gives ERR=0.

Source files
------------

// File: rtl/core_dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state codes, load-size codes,
// captured request record and small strobe-decode helpers.
package core_dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    LSZ_NONE = 2'd0,
    LSZ_BYTE = 2'd1,
    LSZ_HALF = 2'd2,
    LSZ_WORD = 2'd3
  } lsz_e;

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        ld_bs;
    logic        ld_hs;
  } dmem_req_t;

  // Access size is implied by how many lanes are enabled; 3 lanes is treated as a word.
  function automatic lsz_e lsz_from_strb(input logic [3:0] s);
    case (3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]))
      3'd0:    return LSZ_NONE;
      3'd1:    return LSZ_BYTE;
      3'd2:    return LSZ_HALF;
      default: return LSZ_WORD;
    endcase
  endfunction

  function automatic logic strb_contig(input logic [3:0] s);
    case (s)
      4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101: return 1'b0;
      default:                                     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/core_dmem_lane.sv
// Load extraction: mask the SRAM word by the enabled lanes, right-justify by the
// byte offset, then sign/zero-extend according to the access size.
module core_dmem_lane
  import core_dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  strb,
  input  logic        ld_bs,
  input  logic        ld_hs,
  output logic [31:0] rdata
);

  logic [31:0] mask;
  logic [31:0] sh;
  lsz_e        lsz;

  always_comb begin
    mask  = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    sh    = (word & mask) >> {addr_lo, 3'b000};
    lsz   = lsz_from_strb(strb);
    rdata = 32'd0;
    case (lsz)
      LSZ_BYTE: rdata = {{24{ld_bs & sh[7]}}, sh[7:0]};
      LSZ_HALF: rdata = {{16{ld_hs & sh[15]}}, sh[15:0]};
      LSZ_WORD: rdata = sh;
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory responder: single-shot load/store strobes, programmable wait states,
// BUSY/DONE handshake. Optional misalign/range checking under `DMEM_CHECK_EN.
module core_dmem_responder
  import core_dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        ISLOAD_SS,
  input  logic        ISSTORE_SS,
  input  logic [31:0] ADDR,
  input  logic [3:0]  STRB,
  input  logic        ISLOADBS,
  input  logic        ISLOADHWS,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state, state_nx;
  logic [3:0]  cnt;
  dmem_req_t   req_q, req_in, req_eff;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        strobe, commit, in_range, wr_en, ld_zero;
  logic [31:0] offset, rd_word, lane_rd;
  logic [AW-1:0] idx;

  assign strobe = ISLOAD_SS | ISSTORE_SS;

  // A simultaneous load+store strobe is a store: the op bit is just ISSTORE_SS.
  always_comb begin
    req_in = '{st: ISSTORE_SS, addr: ADDR, strb: STRB, wdata: WDATA,
               ld_bs: ISLOADBS, ld_hs: ISLOADHWS};
  end

  // With zero wait states the commit happens on the capture edge, so use live inputs.
  assign req_eff = (state == DMEM_ST_IDLE) ? req_in : req_q;

  always_ff @(posedge CLK) begin
    if (!NRST) state <= DMEM_ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DMEM_ST_IDLE: if (strobe) state_nx = (WAIT_CYCLES == 0) ? DMEM_ST_RESP : DMEM_ST_WAIT;
      DMEM_ST_WAIT: if (cnt == 4'd0) state_nx = DMEM_ST_RESP;
      DMEM_ST_RESP: state_nx = DMEM_ST_IDLE;
      default:      state_nx = DMEM_ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == DMEM_ST_WAIT);
    DONE = (state == DMEM_ST_RESP);
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      cnt   <= 4'd0;
      req_q <= '0;
    end else if (state == DMEM_ST_IDLE && strobe) begin
      cnt   <= WAIT_LD;
      req_q <= req_in;
    end else if (state == DMEM_ST_WAIT && cnt != 4'd0) begin
      cnt   <= cnt - 4'd1;
    end
  end

  assign commit   = NRST && (state_nx == DMEM_ST_RESP);
  assign offset   = req_eff.addr - BASE_ADDR;
  assign in_range = (offset[31:2] < 30'(DEPTH_WORDS));
  assign idx      = offset[AW+1:2];
  assign rd_word  = in_range ? mem[idx] : 32'd0;

  core_dmem_lane u_lane (
    .word    (rd_word),
    .addr_lo (req_eff.addr[1:0]),
    .strb    (req_eff.strb),
    .ld_bs   (req_eff.ld_bs),
    .ld_hs   (req_eff.ld_hs),
    .rdata   (lane_rd)
  );

`ifdef DMEM_CHECK_EN
  lsz_e lsz;
  logic misalign, err_nx, err_q;

  always_comb begin
    lsz      = lsz_from_strb(req_eff.strb);
    misalign = ((lsz == LSZ_HALF) && req_eff.addr[0])
             | ((lsz == LSZ_WORD) && (req_eff.addr[1:0] != 2'b00))
             | !strb_contig(req_eff.strb);
    err_nx   = misalign | !in_range;
  end

  always_ff @(posedge CLK) begin
    if (!NRST) err_q <= 1'b0;
    else       err_q <= commit & err_nx;
  end

  assign ERR     = err_q;
  assign wr_en   = commit & req_eff.st & in_range & !err_nx;
  assign ld_zero = err_nx;
`else
  assign ERR     = 1'b0;
  assign wr_en   = commit & req_eff.st & in_range;
  assign ld_zero = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!NRST)                     rdata_q <= 32'd0;
    else if (commit && !req_eff.st) rdata_q <= ld_zero ? 32'd0 : lane_rd;
  end

  assign RDATA = rdata_q;

  // SRAM has no reset; contents survive NRST.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (req_eff.strb[i]) mem[idx][8*i +: 8] <= req_eff.wdata[8*i +: 8];
    end
  end

endmodule
